// File: rtl/oka_seq_mult_if.sv
// Handshake bundle for oka_seq_mult: operand channel (in_valid/in_ready/a/b)
// and product channel (out_valid/out_ready/y). The master modport is the
// operand source and product consumer; the slave modport is the multiplier.
interface oka_seq_mult_if #(
   parameter int N = 24
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [2*N-2:0]   y;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y
   );
endinterface

// File: rtl/oka_seq_mult.sv
// oka_seq_mult: multi-cycle carry-less (GF(2)[x]) multiplier, overlap-free
// Karatsuba on even/odd coefficient halves. One shared N/2 x N/2 carry-less
// sub-multiplier produces Pe, Po and Pm on consecutive cycles; a registered
// overlap stage recombines them into the 2N-1 coefficient product.
// Optional macro OKA_SEQ_REDUCE_EN adds a bit-serial reduction mod POLY
// (N-1 extra cycles); without it y is the full unreduced product.
module oka_seq_mult #(
   parameter int         N    = 24,
   parameter logic [N:0] POLY = 25'h100001B
) (
   input  logic            clk,
   input  logic            rst_n,
   oka_seq_mult_if.slave   bus
);

   localparam int H = N / 2;       // half-operand width
   localparam int W = 2 * N - 1;   // full product width

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL_E = 3'd1,
      MUL_O = 3'd2,
      MUL_M = 3'd3,
      COMB  = 3'd4,
      RED   = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [N-1:0]    a_r;
   logic [N-1:0]    b_r;
   logic [H-1:0]    ae, ao, am;
   logic [H-1:0]    be, bo, bm;
   logic [H-1:0]    mul_x, mul_y;
   logic [N-2:0]    sub_p;
   logic [N-2:0]    pe, po, pm;
   logic [W-1:0]    comb_y;
   logic [W-1:0]    y_r;
   logic            accept;

`ifdef OKA_SEQ_REDUCE_EN
   localparam int CW = $clog2(W);
   logic [CW-1:0]   cnt;
   logic [W-1:0]    poly_sh;
`endif

   // Only even N >= 4 with a monic modulus of degree N is meaningful; an
   // illegal configuration shows up as this named scope in the hierarchy.
   if ((N % 2) != 0 || N < 4 || POLY[N] != 1'b1) begin : g_illegal_config
   end

   // Carry-less schoolbook product of two half-width operands.
   function automatic logic [N-2:0] clmul_half(input logic [H-1:0] x,
                                               input logic [H-1:0] v);
      logic [N-2:0] r;
      r = '0;
      for (int i = 0; i < H; i++) begin
         if (x[i]) r = r ^ ({{(H-1){1'b0}}, v} << i);
      end
      return r;
   endfunction

   // Zero-interleave: coefficient j moves to bit 2j (substitutes x -> x^2).
   function automatic logic [2*N-4:0] spread(input logic [N-2:0] p);
      logic [2*N-4:0] r;
      r = '0;
      for (int j = 0; j < N - 1; j++) r[2*j] = p[j];
      return r;
   endfunction

   assign accept = bus.in_valid && (state == IDLE);

   // Even/odd split of the captured operands and their Karatsuba middle sums.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      ae = '0; ao = '0; be = '0; bo = '0;
      for (int i = 0; i < H; i++) begin
         ae[i] = a_r[2*i];
         ao[i] = a_r[2*i+1];
         be[i] = b_r[2*i];
         bo[i] = b_r[2*i+1];
      end
      am = ae ^ ao;
      bm = be ^ bo;
   end

   // Operand mux for the shared sub-multiplier, steered by the FSM state.
   always_comb begin
      mul_x = am;
      mul_y = bm;
      case (state)
         MUL_E: begin mul_x = ae; mul_y = be; end
         MUL_O: begin mul_x = ao; mul_y = bo; end
         default: ;
      endcase
   end

   assign sub_p = clmul_half(mul_x, mul_y);

   // Overlap-free recombination; each term is placed by concatenation so the
   // sum lands exactly in 2N-1 bits.
   always_comb begin
      comb_y = {2'b00, spread(pe)}
             ^ {1'b0, spread(pe ^ po ^ pm), 1'b0}
             ^ {spread(po), 2'b00};
   end

`ifdef OKA_SEQ_REDUCE_EN
   // Modulus aligned under the current leading coefficient cnt.
   always_comb begin
      poly_sh = {{(N-2){1'b0}}, POLY} << (cnt - CW'(N));
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: strict walk through the three products, recombine,
   // optional reduction, then hold in DONE until the consumer accepts.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = MUL_E;
         MUL_E: state_nxt = MUL_O;
         MUL_O: state_nxt = MUL_M;
         MUL_M: state_nxt = COMB;
`ifdef OKA_SEQ_REDUCE_EN
         COMB:  state_nxt = RED;
         RED:   if (cnt == CW'(N)) state_nxt = DONE;
`else
         COMB:  state_nxt = DONE;
`endif
         DONE:  if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers: operand capture, sub-products, result and reduction.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: all datapath registers are cleared by reset so an aborted
      // operation leaves no stale partial products or result behind.
      if (!rst_n) begin
         a_r <= '0;
         b_r <= '0;
         pe  <= '0;
         po  <= '0;
         pm  <= '0;
         y_r <= '0;
`ifdef OKA_SEQ_REDUCE_EN
         cnt <= '0;
`endif
      end else begin
         if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
         end
         case (state)
            MUL_E: pe <= sub_p;
            MUL_O: po <= sub_p;
            MUL_M: pm <= sub_p;
            COMB: begin
               y_r <= comb_y;
`ifdef OKA_SEQ_REDUCE_EN
               cnt <= CW'(W - 1);
`endif
            end
`ifdef OKA_SEQ_REDUCE_EN
            RED: begin
               if (y_r[cnt]) y_r <= y_r ^ poly_sh;
               if (cnt != CW'(N)) cnt <= cnt - 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.y         = y_r;

endmodule
